// File: rtl/spike_event_queue_pkg.sv
// Shared types and sizing for the spike event queue and its round-robin arbiter.
package spike_event_queue_pkg;

  localparam int N_PE          = 16;
  localparam int NEURON_ADDR_W = $clog2(N_PE);
  localparam int DEPTH         = 8;
  localparam int PTR_W         = $clog2(DEPTH);
  localparam int COUNT_W       = $clog2(DEPTH + 1);

  typedef logic [NEURON_ADDR_W-1:0] neuron_addr_t;
  typedef logic [N_PE-1:0]          spike_vec_t;
  typedef logic [PTR_W-1:0]         fifo_ptr_t;
  typedef logic [COUNT_W-1:0]       count_t;

  // One-hot ack vector for the PE at address a.
  function automatic spike_vec_t addr_to_onehot(input neuron_addr_t a);
    return spike_vec_t'(1) << a;
  endfunction

  // Round-robin successor of a PE address, wrapping at N_PE.
  function automatic neuron_addr_t next_rr(input neuron_addr_t a);
    return (a == neuron_addr_t'(N_PE - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/spike_event_queue_if.sv
// PE request/ack lines and host drain port of the spike event queue.
interface spike_event_queue_if;
  import spike_event_queue_pkg::*;

  spike_vec_t   spike;
  spike_vec_t   spike_done;
  logic         snn_ren;
  neuron_addr_t neuron_addr_out;
  logic         snn_event_n;
  count_t       count;

  // Environment side: PE array plus host reader.
  modport master (
    output spike, snn_ren,
    input  spike_done, neuron_addr_out, snn_event_n, count
  );

  // Queue side.
  modport slave (
    input  spike, snn_ren,
    output spike_done, neuron_addr_out, snn_event_n, count
  );

endinterface

// File: rtl/spike_event_queue_arbiter.sv
// Combinational round-robin arbiter: rotate requests so rr_ptr lands at bit 0,
// pick the lowest set bit, then map that index back to a PE address.
module spike_rr_arbiter
  import spike_event_queue_pkg::*;
(
  input  spike_vec_t   req,
  input  neuron_addr_t rr_ptr,
  output logic         grant_v,
  output neuron_addr_t g
);

  localparam logic [NEURON_ADDR_W:0] N_PE_W = (NEURON_ADDR_W + 1)'(N_PE);

  logic [2*N_PE-1:0]        req_dbl;
  spike_vec_t               rot;
  neuron_addr_t             first;
  logic [NEURON_ADDR_W:0]   sum;

  // Rotate, find-first, unrotate.
  always_comb begin
    req_dbl = {req, req};
    rot     = spike_vec_t'(req_dbl >> rr_ptr);
    first   = '0;
    for (int i = N_PE - 1; i >= 0; i--) begin
      if (rot[i]) first = neuron_addr_t'(i);
    end
    grant_v = |rot;
    sum     = {1'b0, first} + {1'b0, rr_ptr};
    g       = (sum >= N_PE_W) ? neuron_addr_t'(sum - N_PE_W) : neuron_addr_t'(sum);
  end

endmodule

// File: rtl/spike_event_queue.sv
// Spike event queue: round-robin ack of PE spikes into a first-word-fall-through
// FIFO of neuron addresses drained by the host. A full queue holds off acks
// unless the host pops in the same cycle, so nothing is ever dropped.
module spike_event_queue
  import spike_event_queue_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  spike_event_queue_if.slave  bus
);

  neuron_addr_t mem [DEPTH];
  fifo_ptr_t    wr_ptr;
  fifo_ptr_t    rd_ptr;
  count_t       cnt;
  neuron_addr_t rr_ptr;

  logic         empty;
  logic         full;
  logic         pop;
  logic         push;
  logic         can_push;
  spike_vec_t   req;
  logic         grant_v;
  neuron_addr_t g;

  assign empty    = (cnt == '0);
  assign full     = (cnt == count_t'(DEPTH));
  assign pop      = bus.snn_ren & ~empty;
  assign can_push = ~full | pop;

  // Requests are only offered to the arbiter when an entry can be taken.
  assign req  = (can_push && !reset) ? bus.spike : '0;
  assign push = grant_v;

  spike_rr_arbiter u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .grant_v (grant_v),
    .g       (g)
  );

  // Mealy ack: the winning PE sees spike_done in the same cycle it is queued.
  always_comb begin
    bus.spike_done = grant_v ? addr_to_onehot(g) : '0;
  end

  assign bus.snn_event_n     = empty;
  assign bus.neuron_addr_out = empty ? '0 : mem[rd_ptr];
  assign bus.count           = cnt;

  // Control state: pointers, occupancy and round-robin position.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= next_rr(g);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage: write the granted address; grant_v is already low during reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= g;
  end

  a_ack_onehot : assert property (@(posedge clock) disable iff (reset)
    $onehot0(bus.spike_done));
  a_count_max : assert property (@(posedge clock) disable iff (reset)
    cnt <= count_t'(DEPTH));
  a_no_overflow : assert property (@(posedge clock) disable iff (reset)
    !(push && full && !pop));

endmodule

// File: tb/tb_spike_event_queue.sv
// Directed bench for spike_event_queue with a round-robin reference and an
// address scoreboard.
module tb_spike_event_queue;
  import spike_event_queue_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  spike_event_queue_if bus ();

  spike_event_queue dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int           n_cmp;
  int           n_err;
  int           m_rr;
  neuron_addr_t sb [$];
  spike_vec_t   sp;
  spike_vec_t   d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the reference, advance the reference.
  task automatic step(input spike_vec_t s, input logic ren, input logic rst,
                      output spike_vec_t done);
    spike_vec_t exp_done;
    bit         exp_pop;
    bit         cp;
    bit         found;
    int         gi;
    bus.spike   = s;
    bus.snn_ren = ren;
    reset       = rst;
    @(negedge clock);
    chk("snn_event_n", {31'd0, bus.snn_event_n}, {31'd0, sb.size() == 0});
    chk("count", {28'd0, bus.count}, sb.size());
    if (sb.size() > 0) chk("head", {28'd0, bus.neuron_addr_out}, {28'd0, sb[0]});
    else               chk("head_idle", {28'd0, bus.neuron_addr_out}, 32'd0);
    exp_pop  = ren && (sb.size() > 0);
    cp       = (sb.size() < DEPTH) || exp_pop;
    exp_done = '0;
    found    = 1'b0;
    gi       = 0;
    if (!rst && cp) begin
      for (int k = 0; k < N_PE; k++) begin
        int idx;
        idx = (m_rr + k) % N_PE;
        if (!found && s[idx]) begin
          found = 1'b1;
          gi    = idx;
        end
      end
    end
    if (found) exp_done[gi] = 1'b1;
    chk("spike_done", {16'd0, bus.spike_done}, {16'd0, exp_done});
    done = bus.spike_done;
    @(posedge clock);
    if (rst) begin
      sb.delete();
      m_rr = 0;
    end else begin
      if (exp_pop) void'(sb.pop_front());
      if (found) begin
        sb.push_back(neuron_addr_t'(gi));
        m_rr = (gi + 1) % N_PE;
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    spike_vec_t   rr_exp [3];
    neuron_addr_t drain_exp [8];
    n_cmp = 0;
    n_err = 0;
    m_rr  = 0;
    reset = 1'b1;
    bus.spike   = '1;
    bus.snn_ren = 1'b0;
    @(posedge clock);
    #1;

    // 1: reset held with all PEs requesting
    repeat (3) step(16'hFFFF, 1'b0, 1'b1, d);

    // 2: single spike, ack, head, pop
    step(16'h0020, 1'b0, 1'b0, d);
    chk("t2_ack", {16'd0, d}, 32'h0020);
    chk("t2_addr", {28'd0, bus.neuron_addr_out}, 32'd5);
    chk("t2_nonempty", {31'd0, bus.snn_event_n}, 32'd0);
    step(16'h0000, 1'b1, 1'b0, d);
    chk("t2_empty", {31'd0, bus.snn_event_n}, 32'd1);
    chk("t2_count", {28'd0, bus.count}, 32'd0);

    // 3: round-robin over 0, 8, 15 with PE clear-on-ack
    step(16'h0000, 1'b0, 1'b1, d);
    rr_exp = '{16'h0001, 16'h0100, 16'h8000};
    sp = 16'h8101;
    for (int k = 0; k < 3; k++) begin
      step(sp, 1'b0, 1'b0, d);
      chk("t3_grant", {16'd0, d}, {16'd0, rr_exp[k]});
      sp &= ~d;
    end
    for (int k = 0; k < 3; k++) begin
      chk("t3_pop", {28'd0, bus.neuron_addr_out}, (k == 0) ? 32'd0 : (k == 1) ? 32'd8 : 32'd15);
      step(16'h0000, 1'b1, 1'b0, d);
    end
    sp = 16'h8001;
    step(sp, 1'b0, 1'b0, d);
    chk("t3_regrant0", {16'd0, d}, 32'h0001);
    sp &= ~d;
    step(sp, 1'b0, 1'b0, d);
    chk("t3_regrant15", {16'd0, d}, 32'h8000);
    repeat (2) step(16'h0000, 1'b1, 1'b0, d);

    // 4: fairness between PEs 1 and 2 re-raising one cycle after ack
    step(16'h0000, 1'b0, 1'b1, d);
    sp = 16'h0006;
    for (int k = 0; k < 8; k++) begin
      step(sp, 1'b1, 1'b0, d);
      chk("t4_alt", {16'd0, d}, (k % 2 == 0) ? 32'h0002 : 32'h0004);
      sp = ~d & 16'h0006;
    end
    step(16'h0000, 1'b1, 1'b0, d);

    // 5: fill, backpressure, pop-and-push on full, drain
    step(16'h0000, 1'b0, 1'b1, d);
    for (int i = 0; i < 8; i++) step(spike_vec_t'(1) << i, 1'b0, 1'b0, d);
    for (int k = 0; k < 3; k++) begin
      step(16'h0200, 1'b0, 1'b0, d);
      chk("t5_held", {16'd0, d}, 32'h0000);
    end
    step(16'h0200, 1'b1, 1'b0, d);
    chk("t5_pushpop", {16'd0, d}, 32'h0200);
    chk("t5_count", {28'd0, bus.count}, 32'd8);
    drain_exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    for (int k = 0; k < 8; k++) begin
      chk("t5_drain", {28'd0, bus.neuron_addr_out}, {28'd0, drain_exp[k]});
      step(16'h0000, 1'b1, 1'b0, d);
    end

    // 6: pointer wrap under interleaved traffic, then reset with entries queued
    step(16'h0000, 1'b0, 1'b1, d);
    repeat (5) step(spike_vec_t'(1) << $urandom_range(0, 15), 1'b0, 1'b0, d);
    repeat (20) step(spike_vec_t'(1) << $urandom_range(0, 15), 1'b1, 1'b0, d);
    chk("t6_count5", {28'd0, bus.count}, 32'd5);
    step(16'hFFFF, 1'b0, 1'b1, d);
    chk("t6_rst_ack", {16'd0, d}, 32'h0000);
    chk("t6_rst_count", {28'd0, bus.count}, 32'd0);
    chk("t6_rst_empty", {31'd0, bus.snn_event_n}, 32'd1);
    step(16'hFFFF, 1'b0, 1'b0, d);
    chk("t6_rr0", {16'd0, d}, 32'h0001);
    step(16'h0000, 1'b1, 1'b0, d);
    step(16'h0000, 1'b0, 1'b0, d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
